// File: rtl/cdi_bus_pkg.sv
// Shared types and widths for the video RAM bus responder.
// Imported by ica_bus_responder.
package cdi_bus_pkg;
   localparam int ADDR_W      = 22;
   localparam int WORD_ADDR_W = 21;
   localparam int DATA_W      = 16;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      ACK
   } state_t;

   typedef enum logic {
      OWN_VID,
      OWN_CPU
   } owner_t;
endpackage

// File: rtl/ica_bus_responder.sv
// Arbitrates video and CPU access to the shared synchronous video RAM.
// One transaction at a time: IDLE -> ISSUE -> (WAIT) -> ACK -> IDLE.
module ica_bus_responder
   import cdi_bus_pkg::*;
#(
   parameter int READ_LATENCY    = 2,
   parameter int MAX_VIDEO_BURST = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [ADDR_W-1:0]      vid_address,
   input  logic                   vid_as,
   output logic [DATA_W-1:0]      vid_dout,
   output logic                   vid_ack,
   input  logic                   cpu_req,
   input  logic                   cpu_we,
   input  logic [ADDR_W-1:0]      cpu_addr,
   input  logic [DATA_W-1:0]      cpu_wdata,
   output logic [DATA_W-1:0]      cpu_rdata,
   output logic                   cpu_ack,
   output logic [WORD_ADDR_W-1:0] mem_addr,
   output logic                   mem_rd,
   output logic                   mem_wr,
   output logic [DATA_W-1:0]      mem_wdata,
   input  logic [DATA_W-1:0]      mem_rdata
);
   localparam int LAT_W   = $clog2(READ_LATENCY + 1);
   localparam int BURST_W = $clog2(MAX_VIDEO_BURST + 1);

   state_t                 r_state;
   state_t                 w_next;
   owner_t                 r_owner;
   logic                   r_we;
   logic [WORD_ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0]      r_wdata;
   logic [LAT_W-1:0]       r_lat;
   logic [BURST_W-1:0]     r_burst;
   logic [DATA_W-1:0]      r_vid_dout;
   logic [DATA_W-1:0]      r_cpu_rdata;

   logic w_cpu_turn;
   logic w_grant_vid;
   logic w_grant_cpu;
   logic w_lat_done;
   logic w_unused_bits;

   assign w_unused_bits = ^{vid_address[0], cpu_addr[0]};

   always_comb begin
      w_cpu_turn  = cpu_req &&
                    (r_burst == BURST_W'(MAX_VIDEO_BURST));
      w_grant_vid = (r_state == IDLE) && vid_as && !w_cpu_turn;
      w_grant_cpu = (r_state == IDLE) && cpu_req &&
                    (w_cpu_turn || !vid_as);
      w_lat_done  = (r_lat == LAT_W'(READ_LATENCY));
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE:  if (w_grant_vid || w_grant_cpu) w_next = ISSUE;
         ISSUE: w_next = r_we ? ACK : WAIT;
         WAIT:  if (w_lat_done) w_next = ACK;
         ACK:   w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= IDLE;
         r_owner     <= OWN_VID;
         r_we        <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_lat       <= '0;
         r_burst     <= '0;
         r_vid_dout  <= '0;
         r_cpu_rdata <= '0;
      end else begin
         r_state <= w_next;
         if (w_grant_vid) begin
            r_owner <= OWN_VID;
            r_addr  <= vid_address[ADDR_W-1:1];
            r_we    <= 1'b0;
            // Only a contending CPU makes video grants count toward a burst.
            if (!cpu_req)
               r_burst <= '0;
            else if (r_burst != BURST_W'(MAX_VIDEO_BURST))
               r_burst <= r_burst + 1'b1;
         end else if (w_grant_cpu) begin
            r_owner <= OWN_CPU;
            r_addr  <= cpu_addr[ADDR_W-1:1];
            r_we    <= cpu_we;
            r_wdata <= cpu_wdata;
            r_burst <= '0;
         end
         if (r_state == ISSUE)
            r_lat <= LAT_W'(1);
         else if (r_state == WAIT)
            r_lat <= r_lat + 1'b1;
         if (r_state == WAIT && w_lat_done) begin
            if (r_owner == OWN_VID)
               r_vid_dout <= mem_rdata;
            else
               r_cpu_rdata <= mem_rdata;
         end
      end
   end

   assign mem_rd    = (r_state == ISSUE) && !r_we;
   assign mem_wr    = (r_state == ISSUE) && r_we;
   assign mem_addr  = (r_state == ISSUE) ? r_addr : '0;
   assign mem_wdata = mem_wr ? r_wdata : '0;
   assign vid_ack   = (r_state == ACK) && (r_owner == OWN_VID);
   assign cpu_ack   = (r_state == ACK) && (r_owner == OWN_CPU);
   assign vid_dout  = r_vid_dout;
   assign cpu_rdata = r_cpu_rdata;
endmodule

// File: tb/tb_ica_bus_responder.sv
// Scoreboard bench for ica_bus_responder with a latency-accurate RAM model.
// Expected read data is queued on request and popped on each ack.
module tb_ica_bus_responder;
   import cdi_bus_pkg::*;

   localparam int LAT = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic [21:0] vid_address;
   logic        vid_as;
   logic [15:0] vid_dout;
   logic        vid_ack;
   logic        cpu_req;
   logic        cpu_we;
   logic [21:0] cpu_addr;
   logic [15:0] cpu_wdata;
   logic [15:0] cpu_rdata;
   logic        cpu_ack;
   logic [20:0] mem_addr;
   logic        mem_rd;
   logic        mem_wr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int vid_acks = 0;
   int cpu_acks = 0;
   bit log_on = 1'b0;

   logic [15:0] mem [0:1023] = '{default: 16'h0000};
   logic [15:0] pipe [LAT];
   logic        pk_en = 1'b0;
   logic [9:0]  pk_a = '0;
   logic [15:0] pk_d = '0;

   logic [15:0] vid_q [$];
   logic [16:0] cpu_q [$];
   byte         order_log [$];

   always #5 clk = ~clk;

   ica_bus_responder #(
      .READ_LATENCY(LAT),
      .MAX_VIDEO_BURST(4)
   ) dut (
      .clk(clk),
      .reset(reset),
      .vid_address(vid_address),
      .vid_as(vid_as),
      .vid_dout(vid_dout),
      .vid_ack(vid_ack),
      .cpu_req(cpu_req),
      .cpu_we(cpu_we),
      .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata),
      .cpu_ack(cpu_ack),
      .mem_addr(mem_addr),
      .mem_rd(mem_rd),
      .mem_wr(mem_wr),
      .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (pk_en) mem[pk_a] <= pk_d;
      else if (mem_wr) mem[mem_addr[9:0]] <= mem_wdata;
      pipe[0] <= mem_rd ? mem[mem_addr[9:0]] : 16'hxxxx;
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
   end

   assign mem_rdata = pipe[LAT-1];

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic poke(input logic [9:0] a, input logic [15:0] d);
      pk_a  = a;
      pk_d  = d;
      pk_en = 1'b1;
      tick();
      pk_en = 1'b0;
   endtask

   task automatic wait_vid(input int budget);
      int n = 0;
      do begin tick(); n++; end while (!vid_ack && n < budget);
      if (!vid_ack) chk("vid_timeout", 32'd1, 32'd0);
   endtask

   task automatic wait_cpu(input int budget);
      int n = 0;
      do begin tick(); n++; end while (!cpu_ack && n < budget);
      if (!cpu_ack) chk("cpu_timeout", 32'd1, 32'd0);
   endtask

   task automatic do_reset();
      reset   = 1'b1;
      vid_as  = 1'b0;
      cpu_req = 1'b0;
      repeat (3) tick();
      reset = 1'b0;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_rd"},   32'(mem_rd),    32'd0);
      chk({tag, "_wr"},   32'(mem_wr),    32'd0);
      chk({tag, "_addr"}, 32'(mem_addr),  32'd0);
      chk({tag, "_wd"},   32'(mem_wdata), 32'd0);
      chk({tag, "_vack"}, 32'(vid_ack),   32'd0);
      chk({tag, "_cack"}, 32'(cpu_ack),   32'd0);
      chk({tag, "_vdo"},  32'(vid_dout),  32'd0);
      chk({tag, "_crd"},  32'(cpu_rdata), 32'd0);
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (!reset && (vid_ack || cpu_ack))
            chk("ack_excl", 32'(vid_ack & cpu_ack), 32'd0);
         if (!reset && vid_ack) begin
            vid_acks++;
            if (log_on) order_log.push_back("V");
            if (vid_q.size() == 0) chk("vid_unexp", 32'd1, 32'd0);
            else chk("vid_dout", 32'(vid_dout), 32'(vid_q.pop_front()));
         end
         if (!reset && cpu_ack) begin
            logic [16:0] e;
            cpu_acks++;
            if (log_on) order_log.push_back("C");
            if (cpu_q.size() == 0) chk("cpu_unexp", 32'd1, 32'd0);
            else begin
               e = cpu_q.pop_front();
               if (e[16]) chk("cpu_rdata", 32'(cpu_rdata), 32'(e[15:0]));
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0;
      int a1;
      int va;
      string exp_order;
      vid_address = '0;
      cpu_we      = 1'b0;
      cpu_addr    = '0;
      cpu_wdata   = '0;
      do_reset();
      reset = 1'b1;
      tick();
      chk_zero("rst");
      reset = 1'b0;
      poke(10'h200, 16'h1234);
      poke(10'h201, 16'h5A5A);

      // Single video read
      vid_address = 22'h400;
      vid_as = 1'b1;
      vid_q.push_back(16'h1234);
      c0 = cyc;
      tick();
      chk("t1_rd", 32'(mem_rd), 32'd1);
      chk("t1_addr", 32'(mem_addr), 32'h200);
      wait_vid(20);
      chk("t1_lat", 32'(cyc - c0), 32'd4);
      vid_as = 1'b0;
      repeat (6) tick();
      chk("t1_vacks", 32'(vid_acks), 32'd1);
      chk("t1_cacks", 32'(cpu_acks), 32'd0);

      // Address bit 0 ignored
      vid_address = 22'h401;
      vid_as = 1'b1;
      vid_q.push_back(16'h1234);
      c0 = cyc;
      tick();
      chk("t6_addr", 32'(mem_addr), 32'h200);
      wait_vid(20);
      chk("t6_lat", 32'(cyc - c0), 32'd4);
      vid_as = 1'b0;
      tick();

      // Back-to-back instruction fetch
      poke(10'h200, 16'h3000);
      poke(10'h201, 16'h0000);
      vid_address = 22'h400;
      vid_as = 1'b1;
      vid_q.push_back(16'h3000);
      wait_vid(20);
      a1 = cyc;
      vid_address = 22'h402;
      vid_q.push_back(16'h0000);
      tick();
      tick();
      chk("t2_rd", 32'(mem_rd), 32'd1);
      chk("t2_addr", 32'(mem_addr), 32'h201);
      wait_vid(20);
      chk("t2_gap", 32'(cyc - a1), 32'd5);
      vid_as = 1'b0;
      tick();
      poke(10'h200, 16'h1234);
      poke(10'h201, 16'h5A5A);

      // CPU write then video read of the same word
      cpu_addr  = 22'h404;
      cpu_we    = 1'b1;
      cpu_wdata = 16'hBEEF;
      cpu_req   = 1'b1;
      cpu_q.push_back({1'b0, 16'h0000});
      c0 = cyc;
      tick();
      chk("t4_wr", 32'(mem_wr), 32'd1);
      chk("t4_rd", 32'(mem_rd), 32'd0);
      chk("t4_addr", 32'(mem_addr), 32'h202);
      chk("t4_wd", 32'(mem_wdata), 32'hBEEF);
      tick();
      chk("t4_ack", 32'(cpu_ack), 32'd1);
      chk("t4_lat", 32'(cyc - c0), 32'd2);
      cpu_req = 1'b0;
      cpu_we  = 1'b0;
      vid_address = 22'h404;
      vid_as = 1'b1;
      vid_q.push_back(16'hBEEF);
      wait_vid(20);
      vid_as = 1'b0;
      tick();

      // Starvation guard
      do_reset();
      va = cpu_acks;
      log_on = 1'b1;
      vid_address = 22'h400;
      vid_as = 1'b1;
      vid_q.push_back(16'h1234);
      cpu_addr = 22'h404;
      cpu_we = 1'b0;
      cpu_req = 1'b1;
      cpu_q.push_back({1'b1, 16'hBEEF});
      fork
         begin
            for (int k = 0; k < 8; k++) begin
               wait_vid(40);
               if (k < 7) vid_q.push_back(16'h1234);
               else vid_as = 1'b0;
            end
         end
         begin
            for (int k = 0; k < 2; k++) begin
               wait_cpu(80);
               if (k < 1) cpu_q.push_back({1'b1, 16'hBEEF});
               else cpu_req = 1'b0;
            end
         end
      join
      tick();
      log_on = 1'b0;
      exp_order = "VVVVCVVVVC";
      chk("t3_len", 32'(order_log.size()), 32'd10);
      for (int i = 0; i < 10 && i < order_log.size(); i++)
         chk("t3_order", 32'(order_log[i]), 32'(exp_order[i]));
      chk("t3_cacks", 32'(cpu_acks - va), 32'd2);

      // Reset mid-read
      vid_address = 22'h400;
      vid_as = 1'b1;
      tick();
      tick();
      reset  = 1'b1;
      vid_as = 1'b0;
      tick();
      chk_zero("t5");
      va = vid_acks + cpu_acks;
      reset = 1'b0;
      repeat (5) tick();
      chk("t5_noack", 32'(vid_acks + cpu_acks), 32'(va));
      vid_address = 22'h402;
      vid_as = 1'b1;
      vid_q.push_back(16'h5A5A);
      c0 = cyc;
      wait_vid(20);
      chk("t5_lat", 32'(cyc - c0), 32'd4);
      vid_as = 1'b0;
      repeat (3) tick();

      chk("vid_q_empty", 32'(vid_q.size()), 32'd0);
      chk("cpu_q_empty", 32'(cpu_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
